capt_rd_ctrl: RTL
=================

Name: capt_rd_ctrl

Overview:
- Avalon-MM burst read master that drains capture records from the circular capture buffer in host memory and emits the packet bytes as a 32-bit stream for export.
- Each record is a 16-byte header followed by ceil(len/4) data words: word0 = seconds, word1 = nanoseconds, word2 = len, word3 = len.
- The block tracks its own read pointer against the writer's pointer and lap bit, and flags bad headers and overruns.

Parameters:
- MAX_BURST_WORDS, 4, largest Avalon read burst, in words.
- FIFO_DEPTH, 16, depth in words of the internal read-data FIFO; must be at least MAX_BURST_WORDS.
- MAX_PKT_BYTES, 2048, largest legal len value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- enable  in  1  run; deassert to stop after the current record and to clear ERROR
- capt_buf_start  in  32  buffer base byte address, word aligned; sampled when leaving IDLE
- capt_buf_size  in  32  buffer size in bytes, multiple of 4; sampled when leaving IDLE
- wr_ptr  in  32  writer's next write byte address
- wr_lap  in  1  writer lap bit; toggles each time the writer wraps
- rd_ptr  out  32  next byte address to read
- rd_lap  out  1  reader lap bit
- busy  out  1  high in any state other than IDLE
- err_hdr  out  1  sticky: bad header seen
- err_overrun  out  1  sticky: writer lapped the reader
- pkt_count  out  32  records fully streamed
- address  out  32  Avalon byte address
- read  out  1  Avalon read
- burstcount  out  16  burst length in words
- waitrequest  in  1  Avalon stall
- readdata  in  32  Avalon read data
- readdatavalid  in  1  Avalon read beat
- st_data  out  32  stream data, little-endian bytes
- st_valid  out  1  stream valid
- st_ready  in  1  stream ready
- st_sop  out  1  first data word of a packet
- st_eop  out  1  last data word of a packet
- st_empty  out  2  unused bytes in the eop word: (4 - len%4)%4
- st_ts_sec  out  32  seconds from the header; stable from sop through eop acceptance
- st_ts_nsec  out  32  nanoseconds from the header; stable from sop through eop acceptance

Behaviour:
- Reset values: rd_ptr = capt_buf_start, sampled each cycle while reset is asserted; all other outputs 0. FIFO is flushed. Reset mid-burst abandons outstanding beats; the system must reset the fabric at the same time.
- States:
  - IDLE: if enable, latch the buffer registers and go to CHECK.
  - CHECK: if !enable go to IDLE. If rd_ptr != wr_ptr or rd_lap != wr_lap, and the FIFO is empty, and the previous eop has been accepted, go to RD_HDR.
  - RD_HDR: read 4 header words into registers. The burst is split at the buffer end.
  - PARSE (1 cycle): check the header.
    - Good (len0 == len1, 0 < len <= MAX_PKT_BYTES): load words_rem = ceil(len/4), latch the ts outputs, go to RD_DATA.
    - Bad: set err_hdr and go to ERROR.
  - RD_DATA: issue bursts of n = min(MAX_BURST_WORDS, words_rem, words_to_buf_end), only when FIFO free space >= n and no burst is outstanding. When words_rem = 0 and all beats have been received, go to CHECK and increment pkt_count on eop acceptance.
  - ERROR: hold. Leave only when enable is low, then go to IDLE. rd_ptr is not advanced past the bad header.
- Avalon rules:
  - read, address and burstcount stay stable while waitrequest = 1; read drops the cycle after acceptance.
  - At most one burst outstanding; beats are counted on readdatavalid.
  - The FIFO space check guarantees no beat is ever dropped.
- Pointer update:
  - After each burst completes, rd_ptr += 4n.
  - If the result equals capt_buf_start + capt_buf_size, rd_ptr = capt_buf_start and rd_lap toggles.
  - Bursts never cross the buffer end.
- Overrun: sticky err_overrun is set when rd_lap != wr_lap and wr_ptr > rd_ptr. Reading continues.
- Stream:
  - First-word fall-through from the FIFO; st_valid mirrors FIFO non-empty.
  - Data is popped on st_valid && st_ready and stays stable while st_ready is low.
  - sop on the first data word; eop on word ceil(len/4). For a single-word packet, sop and eop are set on the same word.
- Arithmetic: all address math is 32-bit unsigned; words_to_buf_end = (end - rd_ptr) >> 2.

Decomposition:
- Package capt_pkg holds:
  - state enum;
  - HDR_WORDS = 4 and word-index constants HDR_SEC = 0, HDR_NSEC = 1, HDR_LEN0 = 2, HDR_LEN1 = 3;
  - a function ceil_words(len).
  It is shared with the write controller.
- One sub-module, capt_rd_fifo: synchronous FWFT FIFO with a free-word count output. Everything else lives in capt_rd_ctrl.

Test Plan:
1. Buffer at 0x1000, size 0x100. Memory holds a header {5, 7, 10, 10} then 3 data words. Expect:
   - one 4-word read at 0x1000, then a 3-word read at 0x1010;
   - 3 stream words with sop on word 1, eop on word 3, st_empty = 2, st_ts_sec = 5;
   - rd_ptr = 0x101C, pkt_count = 1.
2. rd_ptr = 0x10F8 with a 16-byte header → reads of 2 words at 0x10F8 and 2 words at 0x1000; rd_lap toggles.
3. len = 64 → data read as 4 bursts of 4 words each. With st_ready held low for 20 cycles, expect no new burst once FIFO free space < 4, and no lost or duplicated word.
4. Header len fields {20, 24} → err_hdr = 1 and ERROR state with no data reads. Dropping enable returns the block to IDLE; err_hdr stays set.
5. waitrequest held for 5 cycles on the first burst → address, burstcount and read stay stable throughout; exactly one burst issued.
6. rd_lap = 0, wr_lap = 1, wr_ptr > rd_ptr → err_overrun = 1 and streaming continues.

Source files
------------

// File: rtl/capt_pkg.sv
// Shared definitions for the capture buffer read/write controllers.
//   capt_state_e : read controller state encoding
//   HDR_*        : record header layout (word indices within the 16-byte header)
//   ceil_words   : byte length -> 32-bit word count, rounded up
package capt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_HDR,
    ST_PARSE,
    ST_RD_DATA,
    ST_ERROR
  } capt_state_e;

  localparam int HDR_WORDS = 4;
  localparam int HDR_SEC   = 0;
  localparam int HDR_NSEC  = 1;
  localparam int HDR_LEN0  = 2;
  localparam int HDR_LEN1  = 3;

  function automatic logic [31:0] ceil_words(input logic [31:0] len);
    return {2'b00, len[31:2]} + {31'd0, |len[1:0]};
  endfunction

endpackage

// File: rtl/capt_rd_fifo.sv
// Synchronous first-word-fall-through FIFO for the read data path.
//   clk, reset : clock, synchronous active-low flush
//   i_push     : write i_data (ignored when full)
//   i_pop      : consume o_data (ignored when empty)
//   o_data     : head word, valid whenever o_empty is low
//   o_empty    : no words stored
//   o_free     : number of free word slots
module capt_rd_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic [CW-1:0] o_free
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_free  = CW'(DEPTH) - r_cnt;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push && (r_cnt != CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/capt_rd_ctrl.sv
// Capture buffer drain: Avalon-MM burst read master that walks the circular
// capture buffer record by record and streams packet data out.
//   clk, reset                 : clock, synchronous active-low reset
//   enable                     : run / stop after current record / clear error
//   capt_buf_start/size        : buffer window, latched when leaving IDLE
//   wr_ptr, wr_lap             : writer position
//   rd_ptr, rd_lap             : reader position
//   busy, err_hdr, err_overrun : status (errors sticky)
//   pkt_count                  : records fully streamed
//   address/read/burstcount/waitrequest/readdata/readdatavalid : Avalon master
//   st_*                       : packet stream with per-packet timestamps
module capt_rd_ctrl
  import capt_pkg::*;
#(
  parameter int MAX_BURST_WORDS = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_PKT_BYTES   = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] capt_buf_start,
  input  logic [31:0] capt_buf_size,
  input  logic [31:0] wr_ptr,
  input  logic        wr_lap,
  output logic [31:0] rd_ptr,
  output logic        rd_lap,
  output logic        busy,
  output logic        err_hdr,
  output logic        err_overrun,
  output logic [31:0] pkt_count,
  output logic [31:0] address,
  output logic        read,
  output logic [15:0] burstcount,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic [31:0] st_data,
  output logic        st_valid,
  input  logic        st_ready,
  output logic        st_sop,
  output logic        st_eop,
  output logic [1:0]  st_empty,
  output logic [31:0] st_ts_sec,
  output logic [31:0] st_ts_nsec
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int HW = $clog2(HDR_WORDS);

  capt_state_e r_state, w_next;

  logic [31:0] r_base, r_end, r_rd_ptr, r_hdr_ptr;
  logic        r_rd_lap, r_hdr_lap;
  logic [31:0] r_hdr [HDR_WORDS];
  logic [HW-1:0] r_hdr_idx;
  logic [31:0] r_req_rem;        // words of current phase not yet requested
  logic        r_bact;           // a burst is issued and not fully returned
  logic [15:0] r_beats_rem;
  logic        r_read;
  logic [31:0] r_addr;
  logic [15:0] r_bcnt;
  logic [31:0] r_ts_sec, r_ts_nsec, r_pkt_words, r_st_idx, r_pkt_count;
  logic [1:0]  r_pkt_empty;
  logic        r_eop_pend, r_err_hdr, r_err_ovr;

  logic [31:0] w_wte, w_n, w_free32, w_ptr_adv, w_fifo_data;
  logic [CW-1:0] w_free;
  logic        w_fifo_empty, w_issue, w_push, w_pop, w_eop, w_hdr_ok, w_last_beat;

  // Burst size: capped by max burst, words left in this phase, and buffer end.
  always_comb begin
    w_wte = (r_end - r_rd_ptr) >> 2;
    w_n   = 32'(MAX_BURST_WORDS);
    if (r_req_rem < w_n) w_n = r_req_rem;
    if (w_wte < w_n)     w_n = w_wte;
  end

  assign w_free32    = 32'(w_free);
  assign w_ptr_adv   = r_rd_ptr + {14'd0, r_bcnt, 2'b00};
  assign w_last_beat = readdatavalid && r_bact && (r_beats_rem == 16'd1);
  assign w_hdr_ok    = (r_hdr[HDR_LEN0] == r_hdr[HDR_LEN1]) && (r_hdr[HDR_LEN0] != '0) &&
                       (r_hdr[HDR_LEN0] <= 32'(MAX_PKT_BYTES));
  assign w_push      = readdatavalid && r_bact && (r_state == ST_RD_DATA);
  assign w_pop       = st_valid && st_ready;
  assign w_eop       = st_valid && (r_st_idx == r_pkt_words - 32'd1);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      ST_IDLE:    if (enable) w_next = ST_CHECK;
      ST_CHECK: begin
        if (!enable) w_next = ST_IDLE;
        else if ((r_rd_ptr != wr_ptr || r_rd_lap != wr_lap) && w_fifo_empty && !r_eop_pend)
          w_next = ST_RD_HDR;
      end
      ST_RD_HDR: begin
        w_issue = !r_bact && (r_req_rem != '0);
        if (r_req_rem == '0 && !r_bact) w_next = ST_PARSE;
      end
      ST_PARSE:   w_next = w_hdr_ok ? ST_RD_DATA : ST_ERROR;
      ST_RD_DATA: begin
        // Space for the whole burst must exist up front: beats cannot be stalled.
        w_issue = !r_bact && (r_req_rem != '0) && (w_free32 >= w_n);
        if (r_req_rem == '0 && !r_bact) w_next = ST_CHECK;
      end
      ST_ERROR:   if (!enable) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_base      <= '0;
      r_end       <= '0;
      r_rd_ptr    <= capt_buf_start;
      r_rd_lap    <= 1'b0;
      r_hdr_ptr   <= '0;
      r_hdr_lap   <= 1'b0;
      for (int i = 0; i < HDR_WORDS; i++) r_hdr[i] <= '0;
      r_hdr_idx   <= '0;
      r_req_rem   <= '0;
      r_bact      <= 1'b0;
      r_beats_rem <= '0;
      r_read      <= 1'b0;
      r_addr      <= '0;
      r_bcnt      <= '0;
      r_ts_sec    <= '0;
      r_ts_nsec   <= '0;
      r_pkt_words <= '0;
      r_st_idx    <= '0;
      r_pkt_empty <= '0;
      r_pkt_count <= '0;
      r_eop_pend  <= 1'b0;
      r_err_hdr   <= 1'b0;
      r_err_ovr   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && enable) begin
        r_base <= capt_buf_start;
        r_end  <= capt_buf_start + capt_buf_size;
      end
      if (r_state == ST_CHECK && w_next == ST_RD_HDR) begin
        r_req_rem <= 32'(HDR_WORDS);
        r_hdr_idx <= '0;
        r_hdr_ptr <= r_rd_ptr;
        r_hdr_lap <= r_rd_lap;
      end
      if (w_issue) begin
        r_read      <= 1'b1;
        r_addr      <= r_rd_ptr;
        r_bcnt      <= w_n[15:0];
        r_beats_rem <= w_n[15:0];
        r_bact      <= 1'b1;
        r_req_rem   <= r_req_rem - w_n;
      end else if (r_read && !waitrequest) begin
        r_read <= 1'b0;
      end
      if (readdatavalid && r_bact) begin
        r_beats_rem <= r_beats_rem - 16'd1;
        if (r_state == ST_RD_HDR) begin
          r_hdr[r_hdr_idx] <= readdata;
          r_hdr_idx        <= r_hdr_idx + 1'b1;
        end
      end
      if (w_last_beat) begin
        r_bact <= 1'b0;
        if (w_ptr_adv == r_end) begin
          r_rd_ptr <= r_base;
          r_rd_lap <= ~r_rd_lap;
        end else begin
          r_rd_ptr <= w_ptr_adv;
        end
      end
      if (r_state == ST_PARSE) begin
        if (w_hdr_ok) begin
          r_req_rem   <= ceil_words(r_hdr[HDR_LEN0]);
          r_pkt_words <= ceil_words(r_hdr[HDR_LEN0]);
          r_pkt_empty <= 2'd0 - r_hdr[HDR_LEN0][1:0];
          r_ts_sec    <= r_hdr[HDR_SEC];
          r_ts_nsec   <= r_hdr[HDR_NSEC];
          r_st_idx    <= '0;
          r_eop_pend  <= 1'b1;
        end else begin
          // Park on the bad record so software can inspect it.
          r_err_hdr <= 1'b1;
          r_rd_ptr  <= r_hdr_ptr;
          r_rd_lap  <= r_hdr_lap;
        end
      end
      if (w_pop) begin
        r_st_idx <= r_st_idx + 32'd1;
        if (w_eop) begin
          r_eop_pend  <= 1'b0;
          r_pkt_count <= r_pkt_count + 32'd1;
        end
      end
      if (r_rd_lap != wr_lap && wr_ptr > r_rd_ptr) r_err_ovr <= 1'b1;
    end
  end

  capt_rd_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (readdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_free  (w_free)
  );

  assign rd_ptr      = r_rd_ptr;
  assign rd_lap      = r_rd_lap;
  assign busy        = (r_state != ST_IDLE);
  assign err_hdr     = r_err_hdr;
  assign err_overrun = r_err_ovr;
  assign pkt_count   = r_pkt_count;
  assign address     = r_addr;
  assign read        = r_read;
  assign burstcount  = r_bcnt;
  assign st_data     = w_fifo_data;
  assign st_valid    = !w_fifo_empty;
  assign st_sop      = st_valid && (r_st_idx == '0);
  assign st_eop      = w_eop;
  assign st_empty    = w_eop ? r_pkt_empty : 2'd0;
  assign st_ts_sec   = r_ts_sec;
  assign st_ts_nsec  = r_ts_nsec;

endmodule
